// File: rtl/arb_mux_pkg.sv
// ============================================================================
// arb_mux_pkg : arbitration mode constants and flattened-bus slice macro
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef ARB_MUX_DEFS
`define ARB_MUX_DEFS
`define ARB_MUX_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package arb_mux_pkg;
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
endpackage

`default_nettype wire

// File: rtl/arb_mux_rr_pick.sv
// ============================================================================
// rr_pick : combinational rotate-priority / fixed-priority request encoder
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  input  logic             mode,
  output logic             found,
  output logic [SEL_W-1:0] grant
);

  int w_idx;

  // Walk candidates from lowest to highest priority so the last hit wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    w_idx = 0;
    if (mode == 1'(ARB_FIXED)) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          found = 1'b1;
          grant = SEL_W'(i);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        w_idx = (int'(last) + k) % N;
        if (req[w_idx]) begin
          found = 1'b1;
          grant = SEL_W'(w_idx);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arb_mux.sv
// ============================================================================
// arb_mux : N-channel arbitrating mux with registered valid/ready output
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = 8,
  parameter int SEL_W  = 3,
  parameter int MODE   = ARB_RR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [N*DATA_W-1:0] req_data,
  output logic [N-1:0]        req_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [SEL_W-1:0]    out_sel,
  input  logic                out_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_sel;
  logic [SEL_W-1:0]  r_last;

  logic              w_load;
  logic              w_found;
  logic [SEL_W-1:0]  w_grant;
  logic [DATA_W-1:0] w_sel_data;

  assign w_load = !r_out_valid | out_ready;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (req_valid),
    .last  (r_last),
    .mode  (1'(MODE)),
    .found (w_found),
    .grant (w_grant)
  );

  // No acceptance while reset is asserted: the word would be discarded.
  generate
    for (genvar i = 0; i < N; i++) begin : g_ready
      assign req_ready[i] = rst_n & w_load & w_found & (w_grant == SEL_W'(i));
    end
  endgenerate

  assign w_sel_data = `ARB_MUX_SLICE(req_data, int'(w_grant), DATA_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_last      <= SEL_W'(N - 1);
    end else if (w_load) begin
      r_out_valid <= w_found;
      if (w_found) begin
        r_out_data <= w_sel_data;
        r_out_sel  <= w_grant;
        r_last     <= w_grant;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

`default_nettype wire
